date_display_seq: RTL and testbench
===================================

// Module: date_display_seq
// PURPOSE
//  Sequenced successor to the fixed two-date HEX display. Holds NUM_ENTRIES BCD dates of DIGITS digits.
//  Steps through them on a debounced key press or on an auto-rotate timer, driving active-low 7-seg outputs.
//  Sits between board I/O (KEY/SW) and HEX0..HEX(DIGITS-1) in the board top level.
// PARAMETERS
//  NUM_ENTRIES     2                   number of stored dates (>=1)
//  DIGITS          6                   digits per date / HEX displays driven (1..8)
//  ENTRY_TABLE     {24'h101798,24'h110399} packed BCD, entry e = bits [4*DIGITS*(e+1)-1 : 4*DIGITS*e], digit 0 = LS nibble
//  DEBOUNCE_CYCLES 500000              consecutive stable cycles required to accept a key level (>=1)
//  ROTATE_TICKS    50000000            clk cycles per auto-advance (>=2)
// PORTS
//  clk      in   1               system clock; single clock domain
//  reset    in   1               synchronous, active-high reset
//  key_n    in   1               raw push-button, active low, asynchronous to clk
//  auto_en  in   1               1 = auto-rotate enabled (from a slide switch)
//  hex_n    out  8*DIGITS        7-seg digit d at [8d+7:8d], {dp,g,f,e,d,c,b,a}, active low
//  idx      out  $clog2(NUM_ENTRIES) (min 1)  currently displayed entry index
//  press    out  1               one-cycle pulse per accepted press
// BEHAVIOUR
//  - Reset (synchronous, active-high): idx=0, press=0, hex_n=all 1s (blank), sync flops=1, debounce state=released, counters=0.
//  - key_n passes through a 2-flop synchroniser. Debounce: stable level counter; accepted level changes only after DEBOUNCE_CYCLES
//    consecutive cycles of the synchronised level differing from the accepted level. Any glitch restarts the count.
//  - press=1 for exactly one cycle on the accepted released->pressed transition; no repeat while held. Release produces no pulse.
//  - Rotate counter: runs only while auto_en=1. Holds at 0 while auto_en=0. On reaching ROTATE_TICKS-1: advance, counter->0.
//  - Advance: idx <= (idx==NUM_ENTRIES-1) ? 0 : idx+1. Occurs the cycle after press (press is registered), or on rotate terminal.
//  - press and rotate terminal in the same cycle: advance exactly once; rotate counter->0.
//  - Any press clears the rotate counter, giving a full ROTATE_TICKS dwell after a manual step.
//  - NUM_ENTRIES=1: idx stays 0; press still pulses.
//  - hex_n registered: reflects the current idx with 1-cycle latency. The first cycle after reset deassertion shows blank; entry idx
//    is shown from the next cycle. dp (bit 7) is always 1 (off).
//  - Decode per nibble: 0-9 standard segments; nibble 10-15 -> blank (8'hFF).
//  - Reset asserted mid-debounce or mid-rotate: all state returns to reset values on that edge. No press pulse is emitted.
// CONFIGURATION
//  BLANK_LEADING_ZERO_EN defined: for the displayed entry, every zero digit more significant than the highest non-zero digit
//    shows blank (8'hFF). Digit 0 is never blanked.
//  Not defined: all DIGITS digits are always shown, zeros included.
// STRUCTURE
//  Shared package date_display_pkg: 7-seg constants SEG_0..SEG_9 and SEG_BLANK=8'hFF.
//    Also holds the function idx_width(n) returning max(1,$clog2(n)).
//  Sub-module key_debounce (clk, reset, key_n, DEBOUNCE_CYCLES -> pressed level, press pulse). Instantiated once.
//  Top: rotate counter, idx register, table mux, DIGITS-wide generate loop of decode + output register.
// TESTING (bench: NUM_ENTRIES=2, DIGITS=6, DEBOUNCE_CYCLES=4, ROTATE_TICKS=8, default table)
//  1. Reset 3 cycles, key_n=1, auto_en=0 -> cycle after release hex_n all FF. Next cycle HEX5..0 = 1,1,0,3,9,9, idx=0.
//  2. key_n=0 held 10 cycles -> single press pulse 4 cycles after sync. Next cycle idx=1. hex shows 1,0,1,7,9,8 one cycle later.
//  3. key_n toggles every 2 cycles for 20 cycles -> no press pulse, idx unchanged.
//  4. auto_en=1, no key -> idx toggles 0->1->0 every 8 cycles. auto_en=0 mid-count -> idx frozen, counter held at 0.
//  5. Press accepted on same cycle the rotate counter hits 7 -> idx advances by exactly 1. Next rotate advance 8 cycles later.
//  6. With BLANK_LEADING_ZERO_EN and entry 24'h000042 -> HEX5..2 = FF, HEX1=SEG_4, HEX0=SEG_2.
//     Without the macro -> HEX5..2 = SEG_0. Reset pulsed mid-debounce -> no press, idx=0.

Source files
------------

// File: rtl/date_display_pkg.sv
// Shared constants and helpers for the sequenced date display.
package date_display_pkg;

  // Active-low 7-segment patterns, bit order {dp,g,f,e,d,c,b,a}; dp always off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    DB_RELEASED = 1'b0,
    DB_PRESSED  = 1'b1
  } db_state_e;

  // Index width with a floor of one bit so a single-entry table still has a port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // BCD nibble to segments; non-decimal codes blank the digit.
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button synchroniser and debouncer: accepted level plus a one-cycle press pulse.
module key_debounce
  import date_display_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          differ_c;

  // Two-flop synchroniser for the asynchronous key; idles high (released).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // State, stability counter and press pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DB_RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Count consecutive cycles the synced level disagrees with the accepted one; any agreement restarts.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    differ_c = (state_q == DB_PRESSED) ? sync2_q : ~sync2_q;
    if (differ_c) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        state_d = (state_q == DB_PRESSED) ? DB_RELEASED : DB_PRESSED;
        press_d = (state_q == DB_RELEASED);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign pressed = (state_q == DB_PRESSED);
  assign press   = press_q;

endmodule

// File: rtl/date_display_seq.sv
// Sequenced BCD date display: steps through a table of dates on key press or timer.
// Optional build macro BLANK_LEADING_ZERO_EN blanks leading zero digits (digit 0 always shown).
module date_display_seq
  import date_display_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES     = 2,
  parameter int unsigned DIGITS          = 6,
  parameter logic [4*DIGITS*NUM_ENTRIES-1:0] ENTRY_TABLE = {24'h101798, 24'h110399},
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned ROTATE_TICKS    = 50000000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               key_n,
  input  logic                               auto_en,
  output logic [8*DIGITS-1:0]                hex_n,
  output logic [idx_width(NUM_ENTRIES)-1:0]  idx,
  output logic                               press
);

  localparam int unsigned IW = idx_width(NUM_ENTRIES);
  localparam int unsigned EW = 4 * DIGITS;
  localparam int unsigned RW = $clog2(ROTATE_TICKS);

  logic          key_press, key_level;
  logic          step_c, rot_term_c, adv_c;
  logic [RW-1:0] rot_cnt_q, rot_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [EW-1:0] entry_c;
  logic [DIGITS-1:0] blank_c;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk    (clk),
    .reset  (reset),
    .key_n  (key_n),
    .pressed(key_level),
    .press  (key_press)
  );

  // Manual step: press pulse, qualified by the accepted level that produced it.
  assign step_c = key_press & key_level;

  // Rotate timer and index advance; a press restarts the dwell and coincident events step once.
  always_comb begin
    rot_cnt_d  = rot_cnt_q;
    rot_term_c = 1'b0;
    if (!auto_en) begin
      rot_cnt_d = '0;
    end else begin
      rot_term_c = (rot_cnt_q == RW'(ROTATE_TICKS - 1));
      rot_cnt_d  = (rot_term_c || step_c) ? '0 : rot_cnt_q + RW'(1);
    end
    adv_c = step_c | rot_term_c;
    idx_d = idx_q;
    if (adv_c) begin
      idx_d = (idx_q == IW'(NUM_ENTRIES - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Timer and index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rot_cnt_q <= '0;
      idx_q     <= '0;
    end else begin
      rot_cnt_q <= rot_cnt_d;
      idx_q     <= idx_d;
    end
  end

  // Table mux: pick the entry for the current index.
  always_comb begin
    entry_c = '0;
    for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
      if (idx_q == IW'(e)) entry_c = ENTRY_TABLE[e*EW +: EW];
    end
  end

`ifdef BLANK_LEADING_ZERO_EN
  logic lz_run_c;

  // Blank zeros above the highest non-zero digit, scanning from the top.
  always_comb begin
    blank_c  = '0;
    lz_run_c = 1'b0;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      lz_run_c   = lz_run_c | (entry_c[4*d +: 4] != 4'h0);
      blank_c[d] = ~lz_run_c;
    end
  end
`else
  // Every digit shown, zeros included.
  always_comb begin
    blank_c = '0;
  end
`endif

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    logic [7:0] seg_d, seg_q;

    // Decode one nibble, honouring the blanking mask.
    always_comb begin
      seg_d = blank_c[d] ? SEG_BLANK : seg_decode(entry_c[4*d +: 4]);
    end

    // Registered segment output; blank out of reset.
    always_ff @(posedge clk) begin
      if (reset) seg_q <= SEG_BLANK;
      else       seg_q <= seg_d;
    end

    assign hex_n[8*d +: 8] = seg_q;
  end

  assign idx   = idx_q;
  assign press = key_press;

endmodule

// File: tb/tb_date_display_seq.sv
// Scoreboard bench for date_display_seq: expected presses/advances queued at stimulus time,
// compared cycle-exactly by a negedge monitor.
module tb_date_display_seq;

  logic        clk = 1'b0;
  logic        reset, key_n, auto_en, key2_n;
  logic [47:0] hex_n, hex2_n;
  logic [0:0]  idx, idx2;
  logic        press, press2;

  localparam logic [47:0] HEX_BLANK = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] HEX_E0    = 48'hF9F9_C0B0_9090;  // 1,1,0,3,9,9
  localparam logic [47:0] HEX_E1    = 48'hF9C0_F9F8_9080;  // 1,0,1,7,9,8
`ifdef BLANK_LEADING_ZERO_EN
  localparam logic [47:0] HEX2_EXP  = 48'hFFFF_FFFF_99A4;
`else
  localparam logic [47:0] HEX2_EXP  = 48'hC0C0_C0C0_99A4;
`endif

  always #5 clk = ~clk;

  date_display_seq #(
    .NUM_ENTRIES(2), .DIGITS(6), .ENTRY_TABLE(48'h101798_110399),
    .DEBOUNCE_CYCLES(4), .ROTATE_TICKS(8)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .auto_en(auto_en),
    .hex_n(hex_n), .idx(idx), .press(press)
  );

  date_display_seq #(
    .NUM_ENTRIES(1), .DIGITS(6), .ENTRY_TABLE(24'h000042),
    .DEBOUNCE_CYCLES(4), .ROTATE_TICKS(8)
  ) dut2 (
    .clk(clk), .reset(reset), .key_n(key2_n), .auto_en(1'b1),
    .hex_n(hex2_n), .idx(idx2), .press(press2)
  );

  typedef struct {
    int unsigned cyc;
    logic [0:0]  idx;
  } adv_t;

  adv_t        adv_q[$];
  int unsigned press_exp_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          press2_cnt = 0;
  logic [0:0]  sb_idx;
  logic [0:0]  model_idx = 1'b0;
  logic        mon_exp_press;
  adv_t        mon_adv;
  bit          first = 1'b1;
  bit          rst_prev = 1'b0;
  int unsigned base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_adv(input int unsigned c);
    adv_t a;
    sb_idx = (sb_idx == 1'b1) ? 1'b0 : 1'b1;
    a.cyc  = c;
    a.idx  = sb_idx;
    adv_q.push_back(a);
  endtask

  // Monitor: compare outputs against the queued expectations every cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (rst_prev) begin
        check_val("rst_idx", 64'(idx), 64'(0));
        check_val("rst_press", 64'(press), 64'(0));
        check_val("rst_hex", 64'(hex_n), 64'(HEX_BLANK));
        check_val("rst_hex2", 64'(hex2_n), 64'(HEX_BLANK));
      end
      model_idx = 1'b0;
      first     = 1'b1;
    end else begin
      check_val("hex", 64'(hex_n), 64'(first ? HEX_BLANK : (model_idx == 1'b1 ? HEX_E1 : HEX_E0)));
      check_val("hex2", 64'(hex2_n), 64'(first ? HEX_BLANK : HEX2_EXP));
      first = 1'b0;
      mon_exp_press = 1'b0;
      if (press_exp_q.size() > 0 && press_exp_q[0] == cyc) begin
        void'(press_exp_q.pop_front());
        mon_exp_press = 1'b1;
      end
      check_val("press", 64'(press), 64'(mon_exp_press));
      if (adv_q.size() > 0 && adv_q[0].cyc == cyc) begin
        mon_adv   = adv_q.pop_front();
        model_idx = mon_adv.idx;
      end
      check_val("idx", 64'(idx), 64'(model_idx));
      check_val("idx2", 64'(idx2), 64'(0));
      if (press2) press2_cnt++;
    end
    rst_prev = reset;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; key_n = 1'b1; auto_en = 1'b0; key2_n = 1'b1; sb_idx = 1'b0;
    step(3);
    reset = 1'b0;
    step(4);

    // Single held press: pulse 6 cycles after drive, index step one cycle later.
    key_n = 1'b0;
    press_exp_q.push_back(cyc + 6);
    exp_adv(cyc + 7);
    step(10);
    key_n = 1'b1;
    step(10);

    // Bouncing key never stays stable long enough.
    repeat (5) begin
      key_n = 1'b0; step(2);
      key_n = 1'b1; step(2);
    end
    step(6);

    // Auto-rotate every 8 cycles; disabling mid-count freezes and zeroes the timer.
    auto_en = 1'b1;
    exp_adv(cyc + 8); exp_adv(cyc + 16); exp_adv(cyc + 24);
    step(28);
    auto_en = 1'b0;
    step(10);
    auto_en = 1'b1;
    exp_adv(cyc + 8);
    step(8);
    auto_en = 1'b0;
    step(4);

    // Press mid-dwell restarts the rotate timer.
    key_n = 1'b0;
    base = cyc;
    press_exp_q.push_back(base + 6);
    exp_adv(base + 7);
    step(3);
    auto_en = 1'b1;
    exp_adv(base + 15);
    step(12);
    auto_en = 1'b0; key_n = 1'b1;
    step(10);

    // Press coinciding with rotate terminal advances once; next rotate 8 cycles later.
    auto_en = 1'b1;
    step(1);
    key_n = 1'b0;
    base = cyc;
    press_exp_q.push_back(base + 6);
    exp_adv(base + 7);
    exp_adv(base + 15);
    step(15);
    auto_en = 1'b0; key_n = 1'b1;
    step(10);

    // Single-entry instance: press pulses, index stays put.
    key2_n = 1'b0;
    step(8);
    key2_n = 1'b1;
    step(10);

    // Reset mid-debounce: no pulse, index back to 0, blank first cycle.
    key_n = 1'b0;
    step(3);
    reset = 1'b1; key_n = 1'b1; sb_idx = 1'b0;
    step(1);
    reset = 1'b0;
    step(12);

    check_val("adv_left", 64'(adv_q.size()), 64'(0));
    check_val("press_left", 64'(press_exp_q.size()), 64'(0));
    check_val("press2_cnt", 64'(press2_cnt), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
